// File: rtl/f1_pkg.sv
// rtl/f1_pkg.sv - shared types and LFSR constants for the start-light sequencer
package f1_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LIGHTS = 2'd1,
    S_HOLD   = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  localparam logic [31:0] LFSR_SEED = 32'd1;

  // Maximal-length Fibonacci tap masks; bit i set means stage i+1 feeds the XOR
  function automatic logic [31:0] lfsr_taps(input int w);
    case (w)
      4:       lfsr_taps = 32'h0000_000C;
      5:       lfsr_taps = 32'h0000_0014;
      6:       lfsr_taps = 32'h0000_0030;
      7:       lfsr_taps = 32'h0000_0060;
      8:       lfsr_taps = 32'h0000_00B8;
      9:       lfsr_taps = 32'h0000_0110;
      10:      lfsr_taps = 32'h0000_0240;
      default: lfsr_taps = 32'h0000_0060;
    endcase
  endfunction

endpackage

// File: rtl/f1_light_ctrl_tick_gen.sv
// rtl/f1_light_ctrl_tick_gen.sv - reloadable down-counter producing one tick per n+1 enabled cycles
module tick_gen #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] n,
  output logic             tick
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign tick = en & (count_q == '0);

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = n;
    end else if (tick) begin
      count_d = n;
    end else if (en) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/f1_light_ctrl.sv
// rtl/f1_light_ctrl.sv - start-light sequencer: lamps on one per tick, random hold, then out with done
module f1_light_ctrl
  import f1_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int LIGHTS     = 8,
  parameter int LFSR_WIDTH = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trigger,
  input  logic              abort,
  input  logic [WIDTH-1:0]  n_cfg,
  output logic [LIGHTS-1:0] data_out,
  output logic              busy,
  output logic              done
);

  localparam logic [LFSR_WIDTH-1:0] TAPS = LFSR_WIDTH'(lfsr_taps(LFSR_WIDTH));
  localparam logic [LFSR_WIDTH-1:0] SEED = LFSR_WIDTH'(LFSR_SEED);

  state_e                  state_q, state_d;
  logic [LIGHTS-1:0]       data_q, data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [WIDTH-1:0]        n_reg_q, n_reg_d;
  logic [LFSR_WIDTH-1:0]   hold_q, hold_d;
  logic [LFSR_WIDTH-1:0]   lfsr_q, lfsr_d;
  logic                    trig_q;

  logic                    trig_edge;
  logic                    run;
  logic                    tick;
  logic                    load;
  logic [WIDTH-1:0]        n_sel;

  assign trig_edge = trigger & ~trig_q;
  assign run       = (state_q == S_LIGHTS) || (state_q == S_HOLD);

  tick_gen #(.WIDTH(WIDTH)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (run),
    .load  (load),
    .n     (n_sel),
    .tick  (tick)
  );

  always_comb begin
    lfsr_d  = {lfsr_q[LFSR_WIDTH-2:0], ^(lfsr_q & TAPS)};
    state_d = state_q;
    data_d  = data_q;
    done_d  = 1'b0;
    n_reg_d = n_reg_q;
    hold_d  = hold_q;
    load    = 1'b0;
    n_sel   = n_reg_q;

    // abort outranks every transition, including a simultaneous edge or final hold tick
    if (abort) begin
      state_d = S_IDLE;
      data_d  = '0;
      hold_d  = '0;
      load    = 1'b1;
      n_sel   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          data_d = '0;
          if (trig_edge) begin
            n_reg_d = n_cfg;
            n_sel   = n_cfg;
            load    = 1'b1;
            state_d = S_LIGHTS;
          end
        end
        S_LIGHTS: begin
          if (tick) begin
            data_d = {data_q[LIGHTS-2:0], 1'b1};
            if (data_q[LIGHTS-2]) begin
              state_d = S_HOLD;
              hold_d  = lfsr_q;
              load    = 1'b1;
            end
          end
        end
        S_HOLD: begin
          data_d = '1;
          if (tick) begin
            if (hold_q == LFSR_WIDTH'(1)) begin
              data_d  = '0;
              done_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              hold_d = hold_q - LFSR_WIDTH'(1);
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d == S_LIGHTS) || (state_d == S_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      n_reg_q <= '0;
      hold_q  <= '0;
      lfsr_q  <= SEED;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      n_reg_q <= n_reg_d;
      hold_q  <= hold_d;
      lfsr_q  <= lfsr_d;
      trig_q  <= trigger;
    end
  end

  assign data_out = data_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_f1_light_ctrl.sv
// tb/tb_f1_light_ctrl.sv - randomized check of f1_light_ctrl against a timeline reference model
module tb_f1_light_ctrl;

  localparam int WIDTH  = 16;
  localparam int LIGHTS = 8;
  localparam int LW     = 7;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             trigger = 1'b0;
  logic             abort = 1'b0;
  logic [WIDTH-1:0] n_cfg = '0;
  logic [LIGHTS-1:0] data_out;
  logic             busy;
  logic             done;

  f1_light_ctrl #(.WIDTH(WIDTH), .LIGHTS(LIGHTS), .LFSR_WIDTH(LW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .trigger  (trigger),
    .abort    (abort),
    .n_cfg    (n_cfg),
    .data_out (data_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference: k = clock edges since the accepted trigger, L = hold length in ticks
  int lfsr_m    = 1;
  bit trig_prev = 1'b0;
  bit active    = 1'b0;
  int k         = 0;
  int n_m       = 0;
  int l_m       = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int t_per();
    return n_m + 1;
  endfunction

  function automatic bit at_finish();
    int h;
    h = LIGHTS * t_per();
    return active && (k >= h) && (k == h + l_m * t_per());
  endfunction

  function automatic int exp_data();
    int h;
    h = LIGHTS * t_per();
    if (!active || at_finish()) return 0;
    if (k < h) return (1 << (k / t_per())) - 1;
    return (1 << LIGHTS) - 1;
  endfunction

  function automatic int lfsr_next(input int l);
    int fb;
    fb = ((l >> (LW - 1)) ^ (l >> (LW - 2))) & 1;
    return ((l << 1) | fb) & ((1 << LW) - 1);
  endfunction

  task automatic model_reset();
    lfsr_m    = 1;
    trig_prev = 1'b0;
    active    = 1'b0;
    k         = 0;
  endtask

  task automatic step();
    int  pre;
    bit  edge_seen;
    pre       = lfsr_m;
    lfsr_m    = lfsr_next(lfsr_m);
    edge_seen = trigger && !trig_prev;
    trig_prev = trigger;
    if (abort) begin
      active = 1'b0;
    end else if (active) begin
      if (at_finish()) begin
        active = 1'b0;
      end else begin
        k++;
        if (k == LIGHTS * t_per()) l_m = pre;
      end
    end else if (edge_seen) begin
      active = 1'b1;
      k      = 0;
      n_m    = int'(n_cfg);
    end
    @(posedge clk);
    #1;
    chk("data_out", 32'(data_out), 32'(exp_data()));
    chk("busy", 32'(busy), 32'(active && !at_finish()));
    chk("done", 32'(done), 32'(at_finish()));
  endtask

  task automatic run_to_idle();
    int guard;
    guard = 0;
    while (active && guard < 4000) begin
      step();
      guard++;
    end
    chk("idle_timeout", 32'(active), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    model_reset();
    chk("rst_lfsr", 32'(dut.lfsr_q), 32'd1);
    repeat (3) step();

    // n_cfg=3 with trigger held high the whole run; n_cfg changed mid-run
    n_cfg   = 16'd3;
    trigger = 1'b1;
    repeat (10) step();
    n_cfg = 16'd9;
    run_to_idle();
    repeat (6) step();
    trigger = 1'b0;
    repeat (2) step();

    // n_cfg=0 with a stray pulse during LIGHTS
    n_cfg   = 16'd0;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    repeat (3) step();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    run_to_idle();
    repeat (2) step();

    // abort once three lamps are lit
    n_cfg   = 16'd3;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    for (int i = 0; i < 100 && exp_data() != 7; i++) step();
    chk("reach_07", 32'(exp_data()), 32'd7);
    abort = 1'b1;
    step();
    abort = 1'b0;
    repeat (2) step();

    // abort together with a trigger edge in IDLE
    abort   = 1'b1;
    trigger = 1'b1;
    step();
    abort   = 1'b0;
    trigger = 1'b0;
    repeat (3) step();

    // abort on the final hold tick
    n_cfg   = 16'd1;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    for (int i = 0; i < 4000 && !(active && k >= LIGHTS * t_per() &&
                                  k + 1 == LIGHTS * t_per() + l_m * t_per()); i++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_final_active", 32'(active), 32'd0);
    repeat (3) step();

    // async reset in the middle of HOLD
    n_cfg   = 16'd2;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    for (int i = 0; i < 200 && !(active && k == LIGHTS * t_per() + 1); i++) step();
    chk("in_hold", 32'(data_out), 32'hFF);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_data", 32'(data_out), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    chk("lfsr_after_rst", 32'(dut.lfsr_q), 32'd1);
    repeat (2) step();

    // random traffic
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 9) < 2) trigger = ~trigger;
      abort = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 49) == 0) n_cfg = WIDTH'($urandom_range(0, 3));
      step();
    end
    trigger = 1'b0;
    abort   = 1'b0;
    run_to_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
